stopwatch_ctrl: RTL and testbench

// - Sequences a chain of NUM_DIGITS decade (BCD 0..9) counters as a start/pause/clear stopwatch.
// - Divides clk by PRESCALE to produce a count tick. Stops in DONE when the count reaches a latched BCD limit.
// - Sits between user control pulses (buttons/CPU strobes) and the BCD display path.
//

---
 rtl/stopwatch_pkg.sv | 22 ++
 rtl/bcd_digit.sv | 26 ++
 rtl/stopwatch_ctrl.sv | 108 ++++++++++
 tb/tb_stopwatch_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the BCD stopwatch controller.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10,
        DONE  = 2'b11
    } state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Next value of one decade digit; anything at or above 9 wraps to 0.
    function automatic logic [3:0] bcd_step(input logic [3:0] q, input logic en);
        if (!en)
            return q;
        if (q >= BCD_MAX)
            return 4'd0;
        return q + 4'd1;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade counter of the stopwatch chain, with synchronous clear.
module bcd_digit
    import stopwatch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       clr,
    output logic [3:0] q,
    output logic       carry
);

    // Carry ripples combinationally so the whole chain updates on one tick edge.
    assign carry = en & (q == BCD_MAX);

    // Digit register: clear has priority over counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= 4'd0;
        else if (clr)
            q <= 4'd0;
        else
            q <= bcd_step(q, en);
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Start/pause/clear stopwatch: prescaler, cascaded BCD digits, limit stop.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    clear,
    input  logic [4*NUM_DIGITS-1:0] limit,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic                    tick,
    output logic                    running,
    output logic                    done,
    output logic                    overflow
);

    localparam int PW = $clog2(PRESCALE);

    state_e                            state_q, state_d;
    logic [PW-1:0]                     presc_q, presc_d;
    logic [4*NUM_DIGITS-1:0]           limit_q;
    logic                              tick_q, running_q, done_q, overflow_q;
    logic [NUM_DIGITS-1:0][3:0]        dig;
    logic [NUM_DIGITS-1:0][3:0]        next_cnt;
    logic [NUM_DIGITS:0]               en;
    logic [NUM_DIGITS-1:0]             carry;
    logic                              presc_last, inc, terminal, load;

    assign presc_last = (presc_q == PW'(PRESCALE - 1));
    // Clear on a tick edge suppresses the increment entirely.
    assign inc        = (state_q == RUN) && presc_last && !clear;
    assign load       = (state_q == IDLE) && start && !clear;
    assign en[0]      = inc;

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        bcd_digit u_digit (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (en[i]),
            .clr   (clear),
            .q     (dig[i]),
            .carry (carry[i])
        );
        assign en[i+1]     = carry[i];
        // Post-increment view of the chain, used for the limit compare.
        assign next_cnt[i] = bcd_step(dig[i], en[i]);
    end

    assign terminal = inc && (next_cnt == limit_q);

    // Next-state and prescaler decode; priority clear > pause > start.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        if (clear) begin
            state_d = IDLE;
            presc_d = '0;
        end else begin
            unique case (state_q)
                IDLE: if (start) begin
                    state_d = (limit == '0) ? DONE : RUN;
                    presc_d = '0;
                end
                RUN: begin
                    presc_d = presc_last ? '0 : presc_q + PW'(1);
                    if (pause)         state_d = PAUSE;
                    else if (terminal) state_d = DONE;
                end
                PAUSE: if (start && !pause) state_d = RUN;
                DONE:  state_d = DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State, prescaler, latched limit and registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            limit_q    <= '0;
            tick_q     <= 1'b0;
            running_q  <= 1'b0;
            done_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            if (load)
                limit_q <= limit;
            tick_q     <= inc;
            running_q  <= (state_d == RUN);
            done_q     <= (state_d == DONE);
            overflow_q <= carry[NUM_DIGITS-1];
        end
    end

    assign digits   = dig;
    assign tick     = tick_q;
    assign running  = running_q;
    assign done     = done_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with NUM_DIGITS=2, PRESCALE=4.
module tb_stopwatch_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0, pause = 1'b0, clear = 1'b0;
    logic [7:0] limit = 8'h00;
    logic [7:0] digits;
    logic       tick, running, done, overflow;

    int n_cmp = 0;
    int n_bad = 0;

    stopwatch_ctrl #(.NUM_DIGITS(2), .PRESCALE(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .pause    (pause),
        .clear    (clear),
        .limit    (limit),
        .digits   (digits),
        .tick     (tick),
        .running  (running),
        .done     (done),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st, pa, cl;
        logic [7:0] lim;
        logic [11:0] exp;  // {digits, tick, running, done, overflow}
    } vec_t;

    vec_t tbl[$];

    function automatic logic [11:0] outs();
        return {digits, tick, running, done, overflow};
    endfunction

    task automatic add(input logic st, pa, cl, input logic [7:0] lim,
                       input logic [7:0] d, input logic tk, rn, dn, ov);
        vec_t v;
        v.st = st; v.pa = pa; v.cl = cl; v.lim = lim;
        v.exp = {d, tk, rn, dn, ov};
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, pa, cl, input logic [7:0] lim);
        start = st; pause = pa; clear = cl; limit = lim;
    endtask

    function automatic logic [7:0] to_bcd(input int n);
        return {4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    int ovf_cnt;
    logic run_lost;

    initial begin
        // Reset state
        #1;
        chk("reset_outputs", 32'(outs()), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven sequence: limit 02 run, DONE hold, zero limit, clears, pause on tick
        add(0,0,0,8'h00, 8'h00,0,0,0,0);
        add(1,0,0,8'h02, 8'h00,0,1,0,0);
        for (int i = 0; i < 3; i++) add(0,0,0,8'h00, 8'h00,0,1,0,0);
        add(0,0,0,8'h00, 8'h01,1,1,0,0);
        for (int i = 0; i < 3; i++) add(0,0,0,8'h00, 8'h01,0,1,0,0);
        add(0,0,0,8'h00, 8'h02,1,0,1,0);
        add(1,0,0,8'h00, 8'h02,0,0,1,0);
        add(0,1,0,8'h00, 8'h02,0,0,1,0);
        add(0,0,1,8'h00, 8'h00,0,0,0,0);
        add(1,0,0,8'h00, 8'h00,0,0,1,0);
        add(1,0,1,8'h05, 8'h00,0,0,0,0);
        add(1,0,0,8'h01, 8'h00,0,1,0,0);
        add(0,0,0,8'h00, 8'h00,0,1,0,0);
        add(0,0,0,8'h00, 8'h00,0,1,0,0);
        add(0,0,1,8'h00, 8'h00,0,0,0,0);
        add(1,0,0,8'h01, 8'h00,0,1,0,0);
        for (int i = 0; i < 3; i++) add(0,0,0,8'h00, 8'h00,0,1,0,0);
        add(0,0,1,8'h00, 8'h00,0,0,0,0);
        add(1,0,0,8'h05, 8'h00,0,1,0,0);
        for (int i = 0; i < 3; i++) add(0,0,0,8'h00, 8'h00,0,1,0,0);
        add(0,1,0,8'h00, 8'h01,1,0,0,0);
        add(0,0,0,8'h00, 8'h01,0,0,0,0);
        add(1,0,0,8'h00, 8'h01,0,1,0,0);
        for (int i = 0; i < 3; i++) add(0,0,0,8'h00, 8'h01,0,1,0,0);
        add(0,0,0,8'h00, 8'h02,1,1,0,0);
        add(0,0,1,8'h00, 8'h00,0,0,0,0);

        foreach (tbl[k]) begin
            drive(tbl[k].st, tbl[k].pa, tbl[k].cl, tbl[k].lim);
            step();
            chk($sformatf("vec%0d", k), 32'(outs()), 32'(tbl[k].exp));
        end
        drive(0,0,0,8'h00);

        // Count to limit 12: first tick after 4 edges, carry 09 -> 10, DONE at 48
        drive(1,0,0,8'h12); step(); drive(0,0,0,8'h00);
        chk("t1_start_running", 32'(running), 32'h1);
        for (int c = 1; c <= 48; c++) begin
            step();
            chk($sformatf("t1_c%0d", c), 32'(outs()),
                32'({to_bcd(c / 4), (c % 4 == 0), (c != 48), (c == 48), 1'b0}));
            if (c == 40) chk("t2_carry_09_to_10", 32'(digits), 32'h10);
        end
        step();
        chk("t1_done_hold", 32'({digits, done, running}), 32'({8'h12, 1'b1, 1'b0}));
        drive(0,0,1,8'h00); step(); drive(0,0,0,8'h00);

        // Pause with prescaler at 2, hold, resume finishes the partial tick
        drive(1,0,0,8'h50); step(); drive(0,0,0,8'h00);
        for (int c = 0; c < 21; c++) step();
        drive(0,1,0,8'h00); step(); drive(0,0,0,8'h00);
        chk("t3_paused", 32'({digits, running}), 32'({8'h05, 1'b0}));
        for (int c = 0; c < 10; c++) begin
            step();
            chk("t3_hold", 32'({digits, tick, running}), 32'({8'h05, 1'b0, 1'b0}));
        end
        drive(1,0,0,8'h00); step(); drive(0,0,0,8'h00);
        chk("t3_resume", 32'({digits, tick, running}), 32'({8'h05, 1'b0, 1'b1}));
        step();
        chk("t3_resume_1", 32'({digits, tick}), 32'({8'h05, 1'b0}));
        step();
        chk("t3_resume_tick", 32'({digits, tick}), 32'({8'h06, 1'b1}));
        drive(0,0,1,8'h00); step(); drive(0,0,0,8'h00);

        // Unreachable limit: 100 ticks wrap 99 -> 00 with a single overflow pulse
        drive(1,0,0,8'hAA); step(); drive(0,0,0,8'h00);
        ovf_cnt = 0;
        run_lost = 1'b0;
        for (int c = 1; c <= 404; c++) begin
            step();
            if (overflow) ovf_cnt++;
            if (!running) run_lost = 1'b1;
            if (c == 396) chk("t4_at_99", 32'(digits), 32'h99);
            if (c == 400) chk("t4_wrap", 32'({digits, overflow, running}), 32'({8'h00, 1'b1, 1'b1}));
            if (c == 401) chk("t4_ovf_drop", 32'(overflow), 32'h0);
        end
        chk("t4_ovf_count", 32'(ovf_cnt), 32'd1);
        chk("t4_still_running", 32'(run_lost), 32'h0);
        drive(0,0,1,8'h00); step(); drive(0,0,0,8'h00);

        // Zero limit goes straight to DONE and never ticks
        drive(1,0,0,8'h00); step(); drive(0,0,0,8'h00);
        chk("t5_zero_done", 32'(outs()), 32'({8'h00, 1'b0, 1'b0, 1'b1, 1'b0}));
        drive(1,0,1,8'h00); step(); drive(0,0,0,8'h00);
        chk("t5_clear_start", 32'(outs()), 32'h0);

        // Asynchronous reset mid-run at 37, then a clean restart
        drive(1,0,0,8'h99); step(); drive(0,0,0,8'h00);
        for (int c = 0; c < 150; c++) step();
        chk("t6_at_37", 32'(digits), 32'h37);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_reset", 32'(outs()), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1,0,0,8'h99); step(); drive(0,0,0,8'h00);
        for (int c = 1; c <= 3; c++) begin
            step();
            chk("t6_no_early_tick", 32'({digits, tick}), 32'({8'h00, 1'b0}));
        end
        step();
        chk("t6_first_tick", 32'({digits, tick}), 32'({8'h01, 1'b1}));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Safety net against a stuck simulation.
    initial begin
        #200000;
        $display("FAIL timeout: simulation ran past its time budget");
        $fatal(1);
    end

endmodule
